// File: rtl/race_if.sv
// race_if: game-control handshake and car-position bus between the physics side
// (master) and the race controller (slave).
interface race_if;
    logic       start;
    logic [9:0] p1_x, p1_y, p2_x, p2_y;
    logic [2:0] state;
    logic [1:0] countdown, p1_lap, p2_lap, winner;
    logic [7:0] race_sec;
    modport master (
        output start, p1_x, p1_y, p2_x, p2_y,
        input  state, countdown, p1_lap, p2_lap, winner, race_sec
    );
    modport slave (
        input  start, p1_x, p1_y, p2_x, p2_y,
        output state, countdown, p1_lap, p2_lap, winner, race_sec
    );
endinterface

// File: rtl/race_fsm.sv
// race_fsm: two-player race controller; countdown, checkpoint-armed lap counting,
// winner detection and a saturating race timer.
module race_fsm #(
    parameter int         SEC_CYCLES = 100000000,
    parameter int         LAPS       = 3,
    parameter logic [9:0] FIN_X0     = 10'd5,
    parameter logic [9:0] FIN_X1     = 10'd35,
    parameter logic [9:0] FIN_Y0     = 10'd120,
    parameter logic [9:0] FIN_Y1     = 10'd130,
    parameter logic [9:0] CP_X0      = 10'd150,
    parameter logic [9:0] CP_X1      = 10'd170,
    parameter logic [9:0] CP_Y0      = 10'd0,
    parameter logic [9:0] CP_Y1      = 10'd239
) (
    input logic  clk,
    input logic  rst,
    race_if.slave bus
);
    localparam int SW = SEC_CYCLES > 1 ? $clog2(SEC_CYCLES) : 1;
    typedef enum logic [2:0] {IDLE = 3'd0, COUNTDOWN = 3'd3, RACING = 3'd4, FINISH = 3'd5} state_t;
    state_t          state_q, state_d;
    logic [SW-1:0]   sec_q, sec_d;
    logic [1:0]      cd_q, cd_d, winner_q, winner_d;
    logic [7:0]      race_sec_q, race_sec_d;
    logic [1:0][1:0] lap_q, lap_d;
    logic [1:0][9:0] px, py;
    logic [1:0]      armed_q, armed_d, in_fin_q, in_fin_d, in_fin, in_cp, lap_hit, win;
    logic            tick;
    function automatic logic in_box(input logic [9:0] x, y, x0, x1, y0, y1);
        return x >= x0 && x <= x1 && y >= y0 && y <= y1;
    endfunction
    assign px   = {bus.p2_x, bus.p1_x};
    assign py   = {bus.p2_y, bus.p1_y};
    assign tick = sec_q == SW'(SEC_CYCLES - 1);
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            in_fin[i] = in_box(px[i], py[i], FIN_X0, FIN_X1, FIN_Y0, FIN_Y1);
            in_cp[i]  = in_box(px[i], py[i], CP_X0, CP_X1, CP_Y0, CP_Y1);
        end
    end
    always_comb begin
        state_d    = state_q;
        cd_d       = cd_q;
        winner_d   = winner_q;
        race_sec_d = race_sec_q;
        lap_d      = lap_q;
        armed_d    = armed_q;
        in_fin_d   = in_fin_q;
        lap_hit    = '0;
        win        = '0;
        case (state_q)
            IDLE: begin
                state_d = bus.start ? COUNTDOWN : IDLE;
                cd_d    = bus.start ? 2'd3 : cd_q;
            end
            COUNTDOWN: begin
                if (tick && cd_q <= 2'd1) begin
                    state_d    = RACING;
                    cd_d       = '0;
                    winner_d   = '0;
                    race_sec_d = '0;
                    lap_d      = '0;
                    armed_d    = '0;
                    in_fin_d   = '0;
                end else if (tick) begin
                    cd_d = cd_q - 2'd1;
                end
            end
            RACING: begin
                race_sec_d = (tick && race_sec_q != 8'hff) ? race_sec_q + 8'd1 : race_sec_q;
                // A car straddling both boxes only arms; the lap needs a later entry edge.
                for (int i = 0; i < 2; i++) begin
                    lap_hit[i]  = armed_q[i] && in_fin[i] && !in_fin_q[i] && !in_cp[i] && lap_q[i] != 2'(LAPS);
                    win[i]      = lap_hit[i] && lap_q[i] == 2'(LAPS - 1);
                    armed_d[i]  = in_cp[i] || (armed_q[i] && !lap_hit[i]);
                    in_fin_d[i] = in_fin[i];
                    lap_d[i]    = lap_q[i] + 2'(lap_hit[i]);
                end
                winner_d = |win ? win : winner_q;
                state_d  = |win ? FINISH : RACING;
            end
            FINISH: begin
                if (bus.start) begin
                    state_d    = IDLE;
                    cd_d       = '0;
                    winner_d   = '0;
                    race_sec_d = '0;
                    lap_d      = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        sec_d = (state_d != state_q || tick) ? '0 : sec_q + SW'(1);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sec_q      <= '0;
            cd_q       <= '0;
            winner_q   <= '0;
            race_sec_q <= '0;
            lap_q      <= '0;
            armed_q    <= '0;
            in_fin_q   <= '0;
        end else begin
            state_q    <= state_d;
            sec_q      <= sec_d;
            cd_q       <= cd_d;
            winner_q   <= winner_d;
            race_sec_q <= race_sec_d;
            lap_q      <= lap_d;
            armed_q    <= armed_d;
            in_fin_q   <= in_fin_d;
        end
    end
    assign bus.state     = state_q;
    assign bus.countdown = cd_q;
    assign bus.winner    = winner_q;
    assign bus.race_sec  = race_sec_q;
    assign bus.p1_lap    = lap_q[0];
    assign bus.p2_lap    = lap_q[1];
endmodule
